// File: rtl/serial_link_pkg.sv
// Shared definitions for the serial link: FSM state encoding and line levels.
// Both the transmitter and the receiver import this package.
package serial_link_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/bit_timer.sv
// Free-running bit-period counter: tick marks the last clk of each serial bit.
// clr holds the count at zero so the first bit after a clear lasts a full period.
module bit_timer #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);

   logic [CW-1:0] count;

   assign tick = (count == LAST);

   always_ff @(posedge clk) begin
      if (!rst) begin
         count <= '0;
      end else if (clr || tick) begin
         count <= '0;
      end else begin
         count <= count + ONE;
      end
   end

endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-in, serial-out frame transmitter: start bit, DATA_W bits LSB-first, stop bit.
// Handshake: a word transfers on a posedge where tx_valid and tx_ready are both high.
module serial_frame_tx
   import serial_link_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              tx_out,
   output logic              busy,
   output logic              done
);

   localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);
   localparam logic [IW-1:0] IDX_ONE  = IW'(1);

   state_t              state;
   logic [DATA_W-1:0]   shift;
   logic [DATA_W-1:0]   shift_next;
   logic [IW-1:0]       idx;
   logic                tick;

   assign shift_next = shift >> 1;

   // The timer is held cleared while idle, so the accept edge starts a fresh period.
   bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_bit_timer (
      .clk (clk),
      .rst (rst),
      .clr (state == IDLE),
      .tick(tick)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         tx_out   <= LINE_IDLE;
         tx_ready <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
         idx      <= '0;
         shift    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (tx_ready && tx_valid) begin
                  shift    <= tx_data;
                  state    <= START;
                  tx_out   <= START_BIT;
                  busy     <= 1'b1;
                  tx_ready <= 1'b0;
               end
            end
            START: begin
               if (tick) begin
                  state  <= DATA;
                  tx_out <= shift[0];
                  idx    <= '0;
               end
            end
            DATA: begin
               if (tick) begin
                  if (idx < IDX_LAST) begin
                     shift  <= shift_next;
                     idx    <= idx + IDX_ONE;
                     tx_out <= shift_next[0];
                  end else begin
                     state  <= STOP;
                     tx_out <= STOP_BIT;
                  end
               end
            end
            STOP: begin
               if (tick) begin
                  state    <= IDLE;
                  busy     <= 1'b0;
                  tx_ready <= 1'b1;
                  done     <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
Parallel-in, serial-out frame transmitter: accepts one DATA_W-bit word over a valid/ready handshake and shifts it onto a single line as start bit (0), data LSB-first, stop bit (1). This is the transmit end of the lab's serial link, and it feeds the team's shift-register receiver. The block is built from edge-triggered registers with synchronous active-low reset, and all outputs are registered.

Parameters:
DATA_W, 8, payload bits per frame (>=1)
CLKS_PER_BIT, 4, clk cycles each serial bit is held on tx_out (>=1)

Ports:
clk  input  1  clock; all state changes on posedge
rst  input  1  synchronous reset, active-low; sampled only on posedge clk
tx_data  input  DATA_W  word to send; sampled only on the accept edge
tx_valid  input  1  producer has a word
tx_ready  output  1  block can accept; registered
tx_out  output  1  serial line; idle high; registered
busy  output  1  frame in progress; registered
done  output  1  one-cycle pulse on frame completion; registered

Behaviour:
- Reset: rst=0 at a posedge forces state IDLE, tx_out=1, tx_ready=1, busy=0, done=0, bit counter=0, bit index=0, shift reg=0. tx_valid and tx_data are ignored in that cycle. Reset mid-frame aborts the frame: line is high after that edge and done is not pulsed.
- States: IDLE, START, DATA, STOP (shared encoding).
- Accept edge E0: state==IDLE, tx_ready=1, tx_valid=1, rst=1. At E0: latch tx_data into shift reg, state->START, tx_out<=0, busy<=1, tx_ready<=0, done<=0, counter<=0.
- Bit timer: counter runs 0..CLKS_PER_BIT-1. Tick = (counter==CLKS_PER_BIT-1), and counter wraps to 0 on tick. With CLKS_PER_BIT=1, tick is every cycle.
- START: on tick, state->DATA, tx_out<=shift[0], bit index<=0.
- DATA: on tick, if index<DATA_W-1 then shift right, index+1, tx_out<=next bit. Else state->STOP, tx_out<=1.
- STOP: on tick, state->IDLE, busy<=0, tx_ready<=1, done<=1, tx_out stays 1.
- done is high exactly one cycle: it clears on the next edge unless a new frame completes.
- Frame timing: tx_out is low for cycles [E0, E0+C). Data bit k is driven in [E0+(k+1)C, E0+(k+2)C). Stop bit is driven from E0+(DATA_W+1)C. done/tx_ready rise at E_end = E0+(DATA_W+2)C. Here C=CLKS_PER_BIT.
- Back-to-back: the earliest next accept edge is E_end+1C? No: it is E_end+1 clk, i.e. the stop level is held at least C+1 cycles. Throughput is one frame per (DATA_W+2)C+1 cycles.
- tx_data changes after E0 do not affect the frame in flight.
- tx_valid while tx_ready=0 is ignored. Producer holds tx_valid until accepted; no buffering.
- Widths: counter = max(1,$clog2(CLKS_PER_BIT)); index = max(1,$clog2(DATA_W)); no overflow, since both wrap/reset explicitly.

Decomposition:
- Package serial_link_pkg: state localparams (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3), LINE_IDLE=1'b1, START_BIT=1'b0, STOP_BIT=1'b1. The receiver shares this package.
- Sub-module bit_timer (parameter CLKS_PER_BIT; ports clk, rst, clr, tick): sync active-low reset; clr zeroes the count. It is reused by the receiver.

Test Plan:
- Reset: hold rst=0 for 3 edges with tx_valid=1, tx_data=8'hFF -> tx_out=1, tx_ready=1, busy=0, done=0; no frame starts.
- Single frame: DATA_W=8, C=4, send 8'hA5 -> tx_out bit sequence 0,1,0,1,0,0,1,0,1,1, each bit held exactly 4 cycles. done is a 1-cycle pulse at E0+40, with tx_ready=1 and busy=0 at the same edge.
- Back-to-back: tx_valid held high with 8'h00 then 8'hFF -> second accept at E0+41. Line reads 0x00 frame, stop, 1 extra high cycle, then the 0xFF frame. Exactly 2 done pulses.
- Data stability: change tx_data every cycle after accepting 8'h3C -> serialised bits still 0,0,1,1,1,1,0,0 LSB-first.
- Mid-frame reset: rst=0 for 1 edge during data bit 3 -> tx_out=1 and tx_ready=1 after that edge, no done. The next frame, 8'h81, transmits correctly.
- Corner params: DATA_W=1, C=1, send 1'b1 -> tx_out 0,1,1 over 3 cycles; done at E0+3.
